lpdaq_sample_framer: RTL
========================

Name: lpdaq_sample_framer

Overview:
- Upstream feeder for the LPDAQ AXI FIFO interface.
- Accepts free-running ADC samples, which cannot be back-pressured, and buffers them in an on-chip FIFO.
- Tags every FRAME_LEN-th accepted sample with tlast.
- Drives the 24-bit AXI-Stream input of the AXI FIFO interface, plus the prog_full/prog_empty level flags that interface turns into interrupts.

Parameters:
- DATA_WIDTH, 24: sample width; also the m_axis_tdata width.
- DEPTH, 512: FIFO words; must be a power of 2, at least 4.
- FRAME_LEN, 256: accepted samples per frame; at least 1.
- PROG_FULL_THRESH, 384: prog_full asserts when fill_level >= this value.
- PROG_EMPTY_THRESH, 64: prog_empty asserts when fill_level <= this value.

Ports:
- clk  in  1  single clock for the whole block.
- rst  in  1  asynchronous, active-high reset.
- sample_valid  in  1  one-cycle strobe; a new sample is present.
- sample_data  in  DATA_WIDTH  sample value.
- m_axis_tvalid  out  1  output word valid.
- m_axis_tready  in  1  downstream ready.
- m_axis_tlast  out  1  last sample of a frame.
- m_axis_tdata  out  DATA_WIDTH  output sample.
- fill_level  out  $clog2(DEPTH)+1  words held, including the output stage.
- prog_full  out  1  registered level flag.
- prog_empty  out  1  registered level flag.
- overflow  out  1  sticky; at least one sample has been dropped.
- ovf_clear  in  1  clears overflow.

Behaviour:
- Reset (asynchronous, all flops):
  - Pointers = 0, fill_level = 0, frame counter = 0.
  - m_axis_tvalid = 0, m_axis_tlast = 0, m_axis_tdata = 0.
  - prog_empty = 1, prog_full = 0, overflow = 0.
  - Reset mid-frame discards all stored data; the first sample after reset starts a new frame.
- Write side:
  - Write occurs when sample_valid=1 and full=0, where full = (fill_level == DEPTH) as registered at the start of the cycle.
  - A read handshake in the same cycle does NOT free space for that write. A sample arriving while full is dropped.
  - Each stored word is {tlast_tag, sample_data}, with tlast_tag = (frame_cnt == FRAME_LEN-1).
  - frame_cnt counts accepted samples only and wraps FRAME_LEN-1 -> 0. Dropped samples do not advance it.
- Memory and output:
  - Dual-port RAM with registered read, followed by a single output register. Show-ahead behaviour.
  - Latency: a sample written at edge N into an empty block gives m_axis_tvalid=1 after edge N+2.
  - Full throughput: 1 word/clk when tready is held high.
  - AXIS rules: once tvalid=1, tdata and tlast stay stable until the tready handshake. tvalid never drops without a handshake.
  - Handshake = tvalid & tready.
- fill_level:
  - +1 per write, -1 per handshake; both in the same cycle leaves it unchanged.
  - Range 0..DEPTH; it never wraps.
  - Pointer arithmetic is modulo DEPTH; wrap is transparent.
- prog_full / prog_empty:
  - Computed from next-state fill_level and registered, so both update in the same cycle as fill_level.
- overflow:
  - Set on any dropped sample; cleared by ovf_clear.
  - If a set and ovf_clear occur in the same cycle, set wins.

Optional Feature:
- Macro: SAMPLE_FRAMER_DROP_CNT_EN.
- Defined:
  - Adds output port drop_count [15:0]: a saturating count of dropped samples. It stops at 16'hFFFF.
  - ovf_clear zeroes drop_count. A drop in the same cycle as ovf_clear yields drop_count = 1.
  - Reset value 0.
- Undefined: the port and its counter are absent; all other behaviour is identical.

Decomposition:
- Package lpdaq_framer_pkg holds:
  - default DATA_WIDTH, DEPTH, FRAME_LEN and threshold constants;
  - a function for the fill_level width;
  - the stored-word layout constant (tag bit position = DATA_WIDTH).
- One sub-module, lpdaq_sync_fifo_mem:
  - simple dual-port RAM, (DATA_WIDTH+1) x DEPTH;
  - write port, registered read port with read enable;
  - no reset on the array.
- Pointers, counters, flags and the output stage live in lpdaq_sample_framer.

Test Plan:
All scenarios use DEPTH=16, FRAME_LEN=4, PROG_FULL_THRESH=12, PROG_EMPTY_THRESH=4.
1. Latency and framing: write samples 1..8 on consecutive clocks with tready=1. Expect the first tvalid 2 clocks after the first write, data 1..8 in order, tlast on 4 and 8, then tvalid=0.
2. Fill and overflow: tready=0, 20 consecutive sample_valid strobes. Expect 16 stored, fill_level=16, prog_full=1 from the 12th write, overflow=1 on the 17th strobe, and drop_count=4 when the macro is defined. Draining then returns samples 1..16 with tlast on 4, 8, 12, 16.
3. Simultaneous read and write at full: fill_level=16, sample_valid and a handshake in the same cycle. Expect the sample dropped, fill_level=15, overflow set.
4. Back-pressure stability: toggle tready pseudo-randomly while writing 64 samples. Expect tdata and tlast held while tvalid=1 and tready=0, and no loss or duplication.
5. Flag thresholds: fill to 5 then drain one; prog_empty goes 1->0 at fill_level 5 and 0->1 at fill_level 4. ovf_clear coinciding with a drop leaves overflow=1.
6. Reset mid-frame: assert rst after 2 of 4 samples with 6 words buffered. Expect all outputs at reset values immediately. The next frame's tlast falls on the 4th post-reset sample.

Source files
------------

// File: rtl/lpdaq_framer_pkg.sv
// Shared defaults and helpers for the LPDAQ sample framer.
// Stored FIFO word layout: {tlast_tag, sample}, tag bit at index DATA_WIDTH.
package lpdaq_framer_pkg;

    localparam int DEF_DATA_WIDTH        = 24;
    localparam int DEF_DEPTH             = 512;
    localparam int DEF_FRAME_LEN         = 256;
    localparam int DEF_PROG_FULL_THRESH  = 384;
    localparam int DEF_PROG_EMPTY_THRESH = 64;

    // Bit position of the tlast tag inside a stored word for the default width.
    localparam int DEF_TAG_POS = DEF_DATA_WIDTH;

    // fill_level must represent 0..DEPTH inclusive.
    function automatic int fill_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

    // Tag bit sits directly above the sample bits.
    function automatic int tag_pos(input int data_width);
        return data_width;
    endfunction

endpackage

// File: rtl/lpdaq_sync_fifo_mem.sv
// Simple dual-port RAM with one write port and a registered read port.
// The array itself is not reset; only the read data register is.
module lpdaq_sync_fifo_mem #(
    parameter int WIDTH = 25,
    parameter int DEPTH = 512,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_wr_en,
    input  logic [AW-1:0]    i_wr_addr,
    input  logic [WIDTH-1:0] i_wr_data,
    input  logic             i_rd_en,
    input  logic [AW-1:0]    i_rd_addr,
    output logic [WIDTH-1:0] o_rd_data
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_rd_data;

    // Write port: store the word at the write address.
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    // Read port: registered read, updated only when a read is requested.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_data <= '0;
        end else if (i_rd_en) begin
            r_rd_data <= r_mem[i_rd_addr];
        end
    end

    assign o_rd_data = r_rd_data;

endmodule

// File: rtl/lpdaq_sample_framer.sv
// LPDAQ sample framer: buffers non-stallable ADC samples in a FIFO, tags every
// FRAME_LEN-th accepted sample with tlast and presents them on AXI-Stream.
// Optional macro SAMPLE_FRAMER_DROP_CNT_EN adds a saturating drop_count port.
// Pipeline: RAM (registered read, stage 1) -> output register (show-ahead).
// Valid/ready: a word transfers on a cycle where m_axis_tvalid & m_axis_tready;
// once tvalid is high, tdata/tlast hold and tvalid stays high until that transfer.
module lpdaq_sample_framer
    import lpdaq_framer_pkg::*;
#(
    parameter int DATA_WIDTH        = DEF_DATA_WIDTH,
    parameter int DEPTH             = DEF_DEPTH,
    parameter int FRAME_LEN         = DEF_FRAME_LEN,
    parameter int PROG_FULL_THRESH  = DEF_PROG_FULL_THRESH,
    parameter int PROG_EMPTY_THRESH = DEF_PROG_EMPTY_THRESH
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          sample_valid,
    input  logic [DATA_WIDTH-1:0]         sample_data,
    output logic                          m_axis_tvalid,
    input  logic                          m_axis_tready,
    output logic                          m_axis_tlast,
    output logic [DATA_WIDTH-1:0]         m_axis_tdata,
    output logic [fill_width(DEPTH)-1:0]  fill_level,
    output logic                          prog_full,
    output logic                          prog_empty,
    output logic                          overflow,
    input  logic                          ovf_clear
`ifdef SAMPLE_FRAMER_DROP_CNT_EN
    ,
    output logic [15:0]                   drop_count
`endif
);

    localparam int AW  = $clog2(DEPTH);
    localparam int PW  = AW + 1;
    localparam int FW  = fill_width(DEPTH);
    localparam int WW  = DATA_WIDTH + 1;
    localparam int TAG = tag_pos(DATA_WIDTH);
    localparam int FCW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;

    localparam logic [FW-1:0]  FULL_LVL = FW'(DEPTH);
    localparam logic [FW-1:0]  PF_TH    = FW'(PROG_FULL_THRESH);
    localparam logic [FW-1:0]  PE_TH    = FW'(PROG_EMPTY_THRESH);
    localparam logic [FCW-1:0] FC_LAST  = FCW'(FRAME_LEN - 1);

    logic [PW-1:0]         r_wr_ptr;
    logic [PW-1:0]         r_rd_ptr;
    logic [FCW-1:0]        r_frame_cnt;
    logic [FW-1:0]         r_fill;
    logic                  r_s1_vld;
    logic                  r_tvalid;
    logic                  r_tlast;
    logic [DATA_WIDTH-1:0] r_tdata;
    logic                  r_prog_full;
    logic                  r_prog_empty;
    logic                  r_overflow;

    logic                  w_full;
    logic                  w_wr;
    logic                  w_drop;
    logic                  w_hs;
    logic                  w_load_out;
    logic                  w_s1_to_out;
    logic                  w_rd_en;
    logic                  w_tag;
    logic [WW-1:0]         w_wr_word;
    logic [WW-1:0]         w_rd_word;
    logic [FW-1:0]         w_fill_next;

    // Full is judged on the registered level; a same-cycle read frees nothing.
    assign w_full      = (r_fill == FULL_LVL);
    assign w_wr        = sample_valid & ~w_full;
    assign w_drop      = sample_valid & w_full;
    assign w_hs        = r_tvalid & m_axis_tready;
    assign w_load_out  = ~r_tvalid | m_axis_tready;
    assign w_s1_to_out = r_s1_vld & w_load_out;
    assign w_rd_en     = (r_wr_ptr != r_rd_ptr) & (~r_s1_vld | w_s1_to_out);
    assign w_tag       = (r_frame_cnt == FC_LAST);
    assign w_wr_word   = {w_tag, sample_data};

    lpdaq_sync_fifo_mem #(
        .WIDTH (WW),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk       (clk),
        .rst       (rst),
        .i_wr_en   (w_wr),
        .i_wr_addr (r_wr_ptr[AW-1:0]),
        .i_wr_data (w_wr_word),
        .i_rd_en   (w_rd_en),
        .i_rd_addr (r_rd_ptr[AW-1:0]),
        .o_rd_data (w_rd_word)
    );

    // Next fill level: +1 per write, -1 per handshake, saturation-free by construction.
    always_comb begin
        w_fill_next = r_fill;
        if (w_wr && !w_hs) begin
            w_fill_next = r_fill + FW'(1);
        end else if (!w_wr && w_hs) begin
            w_fill_next = r_fill - FW'(1);
        end
    end

    // Pointers, frame counter, fill level and level flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_frame_cnt  <= '0;
            r_fill       <= '0;
            r_prog_full  <= 1'b0;
            r_prog_empty <= 1'b1;
        end else begin
            if (w_wr) begin
                r_wr_ptr    <= r_wr_ptr + PW'(1);
                r_frame_cnt <= w_tag ? '0 : r_frame_cnt + FCW'(1);
            end
            if (w_rd_en) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            r_fill       <= w_fill_next;
            r_prog_full  <= (w_fill_next >= PF_TH);
            r_prog_empty <= (w_fill_next <= PE_TH);
        end
    end

    // Stage-1 occupancy and the show-ahead output register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_vld <= 1'b0;
            r_tvalid <= 1'b0;
            r_tlast  <= 1'b0;
            r_tdata  <= '0;
        end else begin
            if (w_rd_en) begin
                r_s1_vld <= 1'b1;
            end else if (w_s1_to_out) begin
                r_s1_vld <= 1'b0;
            end
            if (w_load_out) begin
                r_tvalid <= r_s1_vld;
                if (r_s1_vld) begin
                    r_tlast <= w_rd_word[TAG];
                    r_tdata <= w_rd_word[DATA_WIDTH-1:0];
                end
            end
        end
    end

    // Sticky overflow; a drop wins over a simultaneous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_overflow <= 1'b0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
        end else if (ovf_clear) begin
            r_overflow <= 1'b0;
        end
    end

`ifdef SAMPLE_FRAMER_DROP_CNT_EN
    logic [15:0] r_drop_count;

    // Saturating drop counter; a clear with a concurrent drop restarts at 1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_drop_count <= '0;
        end else if (ovf_clear) begin
            r_drop_count <= {15'd0, w_drop};
        end else if (w_drop && (r_drop_count != 16'hFFFF)) begin
            r_drop_count <= r_drop_count + 16'd1;
        end
    end

    assign drop_count = r_drop_count;
`endif

    assign m_axis_tvalid = r_tvalid;
    assign m_axis_tlast  = r_tlast;
    assign m_axis_tdata  = r_tdata;
    assign fill_level    = r_fill;
    assign prog_full     = r_prog_full;
    assign prog_empty    = r_prog_empty;
    assign overflow      = r_overflow;

endmodule
